ring_bus_wr_arbiter: RTL and testbench

//  Shares the single ring-bus node write port between NREQ local requesters.
//  - Round-robin arbitration; each requester holds an 8-bit address + 32-bit word.
//  - Sequences the node handshake: start -> accept pulse -> node idle -> guard gap.
//  - Returns a per-requester ack, or a timeout report when the ring never accepts.
//  - Sits between engine-side message sources and the ring_bus node's write interface.

---
 rtl/ring_bus_pkg.sv | 27 ++
 rtl/ring_bus_wr_arbiter_rr_arbiter.sv | 35 +++
 rtl/ring_bus_wr_arbiter.sv | 135 +++++++++++++
 tb/tb_ring_bus_wr_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_bus_pkg.sv
// Shared ring-bus definitions: bus widths, write-arbiter state encoding and
// the round-robin pointer advance helper used by both arbitration sides.
package ring_bus_pkg;

  localparam int RB_ADDR_W = 8;
  localparam int RB_DATA_W = 32;
  localparam int RB_IDX_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARB       = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_ACC  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_GAP       = 3'd5
  } wr_state_e;

  // Next round-robin start position after granting idx, wrapping at n
  function automatic logic [RB_IDX_W-1:0] rr_next(input logic [RB_IDX_W-1:0] idx,
                                                  input int n);
    if (int'(idx) >= n - 1) begin
      return '0;
    end
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/ring_bus_wr_arbiter_rr_arbiter.sv
// Round-robin request picker. Purely combinational; the caller owns the
// pointer register so the same block can serve the read-side dispatcher.
module rr_arbiter
  import ring_bus_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]     req,
  input  logic [RB_IDX_W-1:0] ptr,
  output logic [NREQ-1:0]     grant,
  output logic [RB_IDX_W-1:0] idx,
  output logic                valid
);

  // Scan upward from ptr, wrapping, and take the first asserted request
  always_comb begin
    int k;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NREQ) begin
        k = k - NREQ;
      end
      if (!valid && req[k]) begin
        valid    = 1'b1;
        idx      = RB_IDX_W'(k);
        grant[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ring_bus_wr_arbiter.sv
// Shares the ring-bus node write port between NREQ local requesters.
// Grants round-robin, runs the start/accept/idle/gap handshake with the node
// and reports either a one-hot ack or a timeout with the aborted index.
module ring_bus_wr_arbiter
  import ring_bus_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4096,
  parameter int GAP     = 8
) (
  input  logic                      i_sysclk,
  input  logic                      i_srst,
  input  logic [NREQ-1:0]           i_req,
  input  logic [NREQ*RB_ADDR_W-1:0] i_req_addr,
  input  logic [NREQ*RB_DATA_W-1:0] i_req_data,
  output logic [NREQ-1:0]           o_ack,
  output logic                      o_timeout,
  output logic [2:0]                o_timeout_id,
  output logic                      o_busy,
  output logic [RB_ADDR_W-1:0]      o_rb_wr_addr,
  output logic [RB_DATA_W-1:0]      o_rb_wr_data,
  output logic                      o_rb_start_wr,
  input  logic                      i_rb_write_ready,
  input  logic                      i_rb_done_wr
);

  localparam int TCNT_W = $clog2(TIMEOUT);
  localparam int GCNT_W = $clog2(GAP) + 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
  localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(GAP - 1);

  wr_state_e           state;
  logic [RB_IDX_W-1:0] ptr;
  logic [RB_IDX_W-1:0] gid;
  logic [NREQ-1:0]     gnt_q;
  logic [TCNT_W-1:0]   tcnt;
  logic [GCNT_W-1:0]   gcnt;

  logic [NREQ-1:0]     arb_grant;
  logic [RB_IDX_W-1:0] arb_idx;
  logic                arb_valid;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .req   (i_req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Write sequencer: grant, raise start, wait for accept or timeout, wait for
  // the node to go idle, then hold off for the guard gap before re-arbitrating
  always_ff @(posedge i_sysclk or posedge i_srst) begin
    if (i_srst) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      gid           <= '0;
      gnt_q         <= '0;
      tcnt          <= '0;
      gcnt          <= '0;
      o_ack         <= '0;
      o_timeout     <= 1'b0;
      o_timeout_id  <= '0;
      o_busy        <= 1'b0;
      o_rb_wr_addr  <= '0;
      o_rb_wr_data  <= '0;
      o_rb_start_wr <= 1'b0;
    end else begin
      o_ack     <= '0;
      o_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|i_req) begin
            state  <= ST_ARB;
            o_busy <= 1'b1;
          end
        end
        ST_ARB: begin
          if (arb_valid) begin
            o_rb_wr_addr <= i_req_addr[int'(arb_idx)*RB_ADDR_W +: RB_ADDR_W];
            o_rb_wr_data <= i_req_data[int'(arb_idx)*RB_DATA_W +: RB_DATA_W];
            gid          <= arb_idx;
            gnt_q        <= arb_grant;
            ptr          <= rr_next(arb_idx, NREQ);
            state        <= ST_ISSUE;
          end else begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        end
        ST_ISSUE: begin
          o_rb_start_wr <= 1'b1;
          tcnt          <= '0;
          state         <= ST_WAIT_ACC;
        end
        ST_WAIT_ACC: begin
          if (i_rb_write_ready) begin
            o_rb_start_wr <= 1'b0;
            o_ack         <= gnt_q;
            state         <= ST_WAIT_DONE;
          end else if (tcnt == TCNT_LAST) begin
            o_rb_start_wr <= 1'b0;
            o_timeout     <= 1'b1;
            o_timeout_id  <= gid;
            state         <= ST_WAIT_DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (i_rb_done_wr) begin
            gcnt  <= '0;
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gcnt == GCNT_LAST) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: begin
          state         <= ST_IDLE;
          o_busy        <= 1'b0;
          o_rb_start_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_bus_wr_arbiter.sv
// Bench for ring_bus_wr_arbiter: directed scenarios drive requests and a
// small node model; expected acks/timeouts go into a scoreboard queue that a
// separate monitor drains whenever the arbiter reports an outcome.
module tb_ring_bus_wr_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int GAP     = 8;

  logic               i_sysclk = 1'b0;
  logic               i_srst;
  logic [NREQ-1:0]    i_req;
  logic [NREQ*8-1:0]  i_req_addr;
  logic [NREQ*32-1:0] i_req_data;
  logic [NREQ-1:0]    o_ack;
  logic               o_timeout;
  logic [2:0]         o_timeout_id;
  logic               o_busy;
  logic [7:0]         o_rb_wr_addr;
  logic [31:0]        o_rb_wr_data;
  logic               o_rb_start_wr;
  logic               i_rb_write_ready;
  logic               i_rb_done_wr;

  typedef struct {
    bit          is_timeout;
    int          id;
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          ready_cyc = -1;
  int          ready_delay = 0;
  logic        inject_ready = 1'b0;
  logic [7:0]  tb_addr [NREQ] = '{8'h03, 8'h1A, 8'h2B, 8'h3C};
  logic [31:0] tb_data [NREQ] = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'hA5A55A5A};

  ring_bus_wr_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT),
    .GAP     (GAP)
  ) dut (
    .i_sysclk         (i_sysclk),
    .i_srst           (i_srst),
    .i_req            (i_req),
    .i_req_addr       (i_req_addr),
    .i_req_data       (i_req_data),
    .o_ack            (o_ack),
    .o_timeout        (o_timeout),
    .o_timeout_id     (o_timeout_id),
    .o_busy           (o_busy),
    .o_rb_wr_addr     (o_rb_wr_addr),
    .o_rb_wr_data     (o_rb_wr_data),
    .o_rb_start_wr    (o_rb_start_wr),
    .i_rb_write_ready (i_rb_write_ready),
    .i_rb_done_wr     (i_rb_done_wr)
  );

  always #4 i_sysclk = ~i_sysclk;

  // Cycle counter plus the cycle in which write_ready was sampled
  always @(posedge i_sysclk) begin
    cyc <= cyc + 1;
    if (i_rb_write_ready) ready_cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkAtLeast(input string name, input int actual, input int minimum);
    checks++;
    if (actual < minimum) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required >= %0d", name, actual, minimum);
    end
  endtask

  task automatic failWait(input string name, input int bound);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got no event, required one within %0d cycles", name, bound);
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] req);
    i_req = req;
  endtask

  task automatic pushExpect(input bit is_timeout, input int id);
    exp_t e;
    e.is_timeout = is_timeout;
    e.id         = id;
    e.addr       = tb_addr[id];
    e.data       = tb_data[id];
    sb.push_back(e);
  endtask

  task automatic waitAck(input string name, input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge i_sysclk);
      if (|o_ack) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) failWait(name, bound);
  endtask

  task automatic waitStart(input string name, input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge i_sysclk);
      if (o_rb_start_wr) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) failWait(name, bound);
  endtask

  task automatic waitIdle(input string name, input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge i_sysclk);
      if (!o_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) failWait(name, bound);
  endtask

  // Ring node model: accepts after ready_delay cycles of start (0 = never),
  // stays busy a few cycles after accepting, idles when start is low
  initial begin : node_model
    int ncnt;
    int npost;
    ncnt = 0;
    npost = 0;
    i_rb_write_ready = 1'b0;
    i_rb_done_wr = 1'b1;
    forever begin
      @(negedge i_sysclk);
      i_rb_write_ready = inject_ready;
      if (i_srst) begin
        ncnt = 0;
        npost = 0;
        i_rb_done_wr = 1'b1;
      end else if (npost > 0) begin
        npost--;
        if (npost == 0) i_rb_done_wr = 1'b1;
      end else if (o_rb_start_wr) begin
        i_rb_done_wr = 1'b0;
        ncnt++;
        if (ncnt == ready_delay) begin
          i_rb_write_ready = 1'b1;
          ncnt = 0;
          npost = 3;
        end
      end else begin
        ncnt = 0;
        i_rb_done_wr = 1'b1;
      end
    end
  end

  // Scoreboard monitor: every ack/timeout must match the oldest expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge i_sysclk);
      if (!i_srst && (|o_ack || o_timeout)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_unexpected: got ack=%b timeout=%b, required no outcome",
                   o_ack, o_timeout);
        end else begin
          e = sb.pop_front();
          if (e.is_timeout) begin
            checkOutput("sb_timeout", 64'(o_timeout), 64'd1);
            checkOutput("sb_timeout_id", 64'(o_timeout_id), 64'(e.id));
            checkOutput("sb_no_ack_on_timeout", 64'(o_ack), 64'd0);
          end else begin
            checkOutput("sb_ack", 64'(o_ack), 64'd1 << e.id);
            checkOutput("sb_no_timeout_on_ack", 64'(o_timeout), 64'd0);
            checkOutput("sb_ack_latency", 64'(cyc), 64'(ready_cyc));
          end
          checkOutput("sb_addr", 64'(o_rb_wr_addr), 64'(e.addr));
          checkOutput("sb_data", 64'(o_rb_wr_data), 64'(e.data));
        end
      end
    end
  end

  // Runaway guard
  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got no completion, required finish before 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    bit ok;
    bit stable;
    int a_cyc;
    int n;
    int hi;

    i_srst = 1'b1;
    applyStimulus('0);
    for (int k = 0; k < NREQ; k++) begin
      i_req_addr[k*8 +: 8]   = tb_addr[k];
      i_req_data[k*32 +: 32] = tb_data[k];
    end

    $display("[TB] reset state");
    repeat (3) @(negedge i_sysclk);
    checkOutput("rst_ack", 64'(o_ack), 64'd0);
    checkOutput("rst_timeout", 64'(o_timeout), 64'd0);
    checkOutput("rst_timeout_id", 64'(o_timeout_id), 64'd0);
    checkOutput("rst_busy", 64'(o_busy), 64'd0);
    checkOutput("rst_start", 64'(o_rb_start_wr), 64'd0);
    checkOutput("rst_addr", 64'(o_rb_wr_addr), 64'd0);
    checkOutput("rst_data", 64'(o_rb_wr_data), 64'd0);
    i_srst = 1'b0;

    $display("[TB] test 1: single requester, accept after 20 cycles");
    ready_delay = 20;
    pushExpect(1'b0, 0);
    applyStimulus(4'b0001);
    @(negedge i_sysclk);
    checkOutput("t1_start_cyc1", 64'(o_rb_start_wr), 64'd0);
    checkOutput("t1_busy_cyc1", 64'(o_busy), 64'd1);
    @(negedge i_sysclk);
    checkOutput("t1_start_cyc2", 64'(o_rb_start_wr), 64'd0);
    checkOutput("t1_addr_latched", 64'(o_rb_wr_addr), 64'h03);
    checkOutput("t1_data_latched", 64'(o_rb_wr_data), 64'hDEADBEEF);
    @(negedge i_sysclk);
    checkOutput("t1_start_cyc3", 64'(o_rb_start_wr), 64'd1);
    ok = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_sysclk);
      if (o_rb_wr_addr !== 8'h03 || o_rb_wr_data !== 32'hDEADBEEF) stable = 1'b0;
      if (|o_ack) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) failWait("t1_ack", 100);
    checkOutput("t1_bus_stable", 64'(stable), 64'd1);
    applyStimulus('0);
    waitIdle("t1_idle", 100);

    $display("[TB] test 2: all requesting, rotation 0..3 twice");
    i_srst = 1'b1;
    @(negedge i_sysclk);
    i_srst = 1'b0;
    ready_delay = 3;
    for (int i = 0; i < 8; i++) pushExpect(1'b0, i % NREQ);
    applyStimulus(4'b1111);
    for (int t = 0; t < 8; t++) begin
      waitAck("t2_ack", 200);
      a_cyc = cyc;
      if (t == 7) begin
        applyStimulus('0);
      end else begin
        waitStart("t2_next_start", 200);
        checkAtLeast("t2_gap", cyc - a_cyc, GAP);
      end
    end
    waitIdle("t2_idle", 100);

    $display("[TB] test 3: node never accepts, timeout then next grant");
    ready_delay = 0;
    pushExpect(1'b1, 2);
    applyStimulus(4'b0100);
    waitStart("t3_start", 50);
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge i_sysclk);
      n++;
      if (o_timeout) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) failWait("t3_timeout", 200);
    checkOutput("t3_timeout_cycle", 64'(n), 64'd64);
    checkOutput("t3_start_dropped", 64'(o_rb_start_wr), 64'd0);
    ready_delay = 5;
    pushExpect(1'b0, 3);
    applyStimulus(4'b1111);
    waitAck("t3_next_ack", 300);
    applyStimulus('0);
    waitIdle("t3_idle", 100);

    $display("[TB] test 4: accept on the final timeout cycle");
    ready_delay = 64;
    pushExpect(1'b0, 0);
    applyStimulus(4'b0001);
    waitAck("t4_ack", 300);
    checkOutput("t4_no_timeout", 64'(o_timeout), 64'd0);
    applyStimulus('0);
    waitIdle("t4_idle", 100);

    $display("[TB] test 5: reset during WAIT_ACC");
    ready_delay = 0;
    applyStimulus(4'b0010);
    waitStart("t5_start", 50);
    repeat (5) @(negedge i_sysclk);
    #1 i_srst = 1'b1;
    #1;
    checkOutput("t5_start_cleared", 64'(o_rb_start_wr), 64'd0);
    checkOutput("t5_busy_cleared", 64'(o_busy), 64'd0);
    checkOutput("t5_no_ack", 64'(o_ack), 64'd0);
    @(negedge i_sysclk);
    ready_delay = 10;
    pushExpect(1'b0, 1);
    i_srst = 1'b0;
    waitAck("t5_ack_after_reset", 100);
    applyStimulus('0);
    waitIdle("t5_idle", 100);

    $display("[TB] test 6: req2 dropped during WAIT_ACC");
    ready_delay = 15;
    pushExpect(1'b0, 2);
    applyStimulus(4'b0100);
    waitStart("t6_start", 50);
    repeat (3) @(negedge i_sysclk);
    applyStimulus('0);
    waitAck("t6_ack", 100);
    waitIdle("t6_idle", 100);
    hi = 0;
    repeat (10) begin
      @(negedge i_sysclk);
      if (o_busy) hi++;
    end
    checkOutput("t6_no_regrant", 64'(hi), 64'd0);

    $display("[TB] test 7: write_ready while idle is ignored");
    @(posedge i_sysclk);
    #2 inject_ready = 1'b1;
    @(posedge i_sysclk);
    #2 inject_ready = 1'b0;
    repeat (5) @(negedge i_sysclk);
    checkOutput("t7_idle_busy", 64'(o_busy), 64'd0);

    repeat (5) @(negedge i_sysclk);
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
